// File: rtl/adc_fifo_writer_if.sv
// Avalon-MM write-only port bundle used between adc_fifo_writer and a
// readout FIFO's write slave.
//
// Handshake: the master raises write with writedata and holds both stable
// while waitrequest is high; a transfer completes on the rising edge where
// write is high and waitrequest is low.
interface adc_fifo_writer_if;
    logic [31:0] writedata;
    logic        write;
    logic        waitrequest;

    modport master (output writedata, output write, input waitrequest);
    modport slave  (input writedata, input write, output waitrequest);
endinterface

// File: rtl/adc_fifo_writer.sv
// Two-channel ADC capture front end: pairs samples into tagged 32-bit words,
// buffers them per channel and writes them out over Avalon-MM write ports.
// Optional internal ramp source selected by test_mode is compiled in only when
// ADC_FIFO_WRITER_TESTPATTERN_EN is defined.
module adc_fifo_writer #(
    parameter int ADC_WIDTH = 12,
    parameter int DEPTH     = 8
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 run,
    input  logic                 test_mode,
    input  logic [ADC_WIDTH-1:0] adc0_data,
    input  logic                 adc0_valid,
    input  logic [ADC_WIDTH-1:0] adc1_data,
    input  logic                 adc1_valid,
    adc_fifo_writer_if.master    fifo_0_in,
    adc_fifo_writer_if.master    fifo_1_in,
    output logic                 ovf_0,
    output logic                 ovf_1,
    output logic [7:0]           drop_cnt_0,
    output logic [7:0]           drop_cnt_1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {EVEN, ODD}   pair_state_t;
    typedef enum logic {IDLE, WRITE} wr_state_t;

    // Per-channel views of the flat ports so both channels share one body.
    logic [ADC_WIDTH-1:0] adc_data    [2];
    logic                 adc_valid   [2];
    logic                 waitrequest [2];

    assign adc_data[0]    = adc0_data;
    assign adc_data[1]    = adc1_data;
    assign adc_valid[0]   = adc0_valid;
    assign adc_valid[1]   = adc1_valid;
    assign waitrequest[0] = fifo_0_in.waitrequest;
    assign waitrequest[1] = fifo_1_in.waitrequest;

`ifndef ADC_FIFO_WRITER_TESTPATTERN_EN
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    logic run_q;
    logic run_rise;

    assign run_rise = run & ~run_q;

    // Previous run level, used to detect the capture-start edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) run_q <= 1'b0;
        else             run_q <= run;
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic                 accept;
        logic                 form;
        logic                 push;
        logic                 pop;
        logic                 drop;
        logic                 full;
        logic                 empty;
        logic                 load;
        logic [ADC_WIDTH-1:0] sample;
        logic [ADC_WIDTH-1:0] first_q;
        logic [31:0]          word;
        logic [3:0]           seq_q;
        logic [31:0]          mem [DEPTH];
        logic [AW-1:0]        rd_ptr;
        logic [AW-1:0]        wr_ptr;
        logic [AW-1:0]        load_addr;
        logic [CW-1:0]        count;
        logic [31:0]          writedata_q;
        logic                 write_q;
        logic                 ovf_q;
        logic [7:0]           drop_q;
        pair_state_t          pair_state;
        pair_state_t          pair_next;
        wr_state_t            wr_state;
        wr_state_t            wr_next;

        assign accept = adc_valid[ch] & run;

`ifdef ADC_FIFO_WRITER_TESTPATTERN_EN
        logic [ADC_WIDTH-1:0] ramp_q;
        logic [ADC_WIDTH-1:0] ramp_base;

        // The ramp restarts on the run edge before the coincident sample uses it.
        assign ramp_base = run_rise ? '0 : ramp_q;
        assign sample    = test_mode ? ramp_base : adc_data[ch];

        // Ramp source: advances once per accepted sample, wraps naturally.
        always_ff @(posedge clk_clk) begin
            if (reset_reset)             ramp_q <= '0;
            else if (run_rise || accept) ramp_q <= ramp_base + ADC_WIDTH'(accept);
        end
`else
        assign sample = adc_data[ch];
`endif

        // A word forms on the second sample of a pair; the run edge always
        // restarts pairing, so a coincident sample is a first half.
        assign form  = accept & ~run_rise & (pair_state == ODD);
        assign word  = {seq_q, 14'(first_q), 14'(sample)};
        assign full  = (count == CW'(DEPTH));
        assign empty = (count == '0);
        assign pop   = (wr_state == WRITE) & ~waitrequest[ch];
        assign push  = form & (~full | pop);
        assign drop  = form & full & ~pop;

        // Pairer next state: run low discards a stored half.
        always_comb begin
            pair_next = pair_state;
            if (!run)          pair_next = EVEN;
            else if (run_rise) pair_next = accept ? ODD : EVEN;
            else if (accept)   pair_next = (pair_state == EVEN) ? ODD : EVEN;
        end

        // Pairer state and the held first half.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                pair_state <= EVEN;
                first_q    <= '0;
            end else begin
                pair_state <= pair_next;
                if (accept && (run_rise || pair_state == EVEN)) first_q <= sample;
            end
        end

        // Sequence tag and overflow bookkeeping; cleared on each capture start.
        always_ff @(posedge clk_clk) begin
            if (reset_reset || run_rise) begin
                seq_q  <= '0;
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end else begin
                if (push) seq_q <= seq_q + 4'd1;
                if (drop) begin
                    ovf_q <= 1'b1;
                    if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                end
            end
        end

        // Word storage; a push into a full buffer reuses the slot popped this cycle.
        always_ff @(posedge clk_clk) begin
            if (push) mem[wr_ptr] <= word;
        end

        // Buffer pointers and occupancy.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        // Write master next state: load the head from IDLE, or the entry
        // behind the completing head for a back-to-back transfer.
        always_comb begin
            wr_next   = wr_state;
            load      = 1'b0;
            load_addr = rd_ptr;
            case (wr_state)
                IDLE: begin
                    if (!empty) begin
                        load    = 1'b1;
                        wr_next = WRITE;
                    end
                end
                WRITE: begin
                    if (!waitrequest[ch]) begin
                        if (count > CW'(1)) begin
                            load      = 1'b1;
                            load_addr = rd_ptr + AW'(1);
                        end else begin
                            wr_next = IDLE;
                        end
                    end
                end
                default: wr_next = IDLE;
            endcase
        end

        // Write master state and registered bus outputs.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                wr_state    <= IDLE;
                write_q     <= 1'b0;
                writedata_q <= '0;
            end else begin
                wr_state <= wr_next;
                write_q  <= (wr_next == WRITE);
                if (load) writedata_q <= mem[load_addr];
            end
        end
    end

    assign fifo_0_in.writedata = g_ch[0].writedata_q;
    assign fifo_0_in.write     = g_ch[0].write_q;
    assign fifo_1_in.writedata = g_ch[1].writedata_q;
    assign fifo_1_in.write     = g_ch[1].write_q;
    assign ovf_0               = g_ch[0].ovf_q;
    assign ovf_1               = g_ch[1].ovf_q;
    assign drop_cnt_0          = g_ch[0].drop_q;
    assign drop_cnt_1          = g_ch[1].drop_q;

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Testbench for adc_fifo_writer: directed scenarios plus a randomized phase,
// checked against a word-level reference model of pairing, tagging and a
// DEPTH-word buffer.
module tb_adc_fifo_writer;
    localparam int W = 12;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         test_mode = 1'b0;
    logic [W-1:0] adc_d  [2];
    logic         adc_v  [2];
    logic         wait_r [2];
    logic         ovf_0, ovf_1;
    logic [7:0]   drop_cnt_0, drop_cnt_1;

    logic         obs_write [2];
    logic [31:0]  obs_data  [2];
    logic         obs_ovf   [2];
    logic [7:0]   obs_drop  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0]  exp_q [2][$];
    logic [31:0]  got_q [2][$];
    int           n_done     [2];
    logic         m_ready    [2];
    logic         m_half_v   [2];
    logic [W-1:0] m_half     [2];
    logic [W-1:0] m_ramp     [2];
    int           m_seq      [2];
    logic         m_ovf      [2];
    int           m_drop     [2];
    logic         m_prev_run [2];
    logic         prev_write [2];
    logic         prev_wait  [2];
    logic [31:0]  prev_data  [2];

    adc_fifo_writer_if f0 ();
    adc_fifo_writer_if f1 ();

    assign f0.waitrequest = wait_r[0];
    assign f1.waitrequest = wait_r[1];
    assign obs_write[0]   = f0.write;
    assign obs_write[1]   = f1.write;
    assign obs_data[0]    = f0.writedata;
    assign obs_data[1]    = f1.writedata;
    assign obs_ovf[0]     = ovf_0;
    assign obs_ovf[1]     = ovf_1;
    assign obs_drop[0]    = drop_cnt_0;
    assign obs_drop[1]    = drop_cnt_1;

    adc_fifo_writer #(.ADC_WIDTH(W), .DEPTH(D)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .run         (run),
        .test_mode   (test_mode),
        .adc0_data   (adc_d[0]),
        .adc0_valid  (adc_v[0]),
        .adc1_data   (adc_d[1]),
        .adc1_valid  (adc_v[1]),
        .fifo_0_in   (f0),
        .fifo_1_in   (f1),
        .ovf_0       (ovf_0),
        .ovf_1       (ovf_1),
        .drop_cnt_0  (drop_cnt_0),
        .drop_cnt_1  (drop_cnt_1)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, one call per channel per cycle on the falling edge:
    // compare status, retire completed transfers, then apply this cycle's inputs.
    task automatic model_step(input int c);
        logic [W-1:0] s;
        logic [31:0]  word;
        if (rst) begin
            exp_q[c].delete();
            m_half_v[c]   = 1'b0;
            m_ramp[c]     = '0;
            m_seq[c]      = 0;
            m_ovf[c]      = 1'b0;
            m_drop[c]     = 0;
            m_prev_run[c] = 1'b0;
            prev_write[c] = 1'b0;
            m_ready[c]    = 1'b1;
            return;
        end
        if (!m_ready[c]) return;
        check($sformatf("ovf_%0d", c), 32'(obs_ovf[c]), 32'(m_ovf[c]));
        check($sformatf("drop_cnt_%0d", c), 32'(obs_drop[c]), 32'(m_drop[c]));
        if (prev_write[c] && prev_wait[c]) begin
            check($sformatf("hold_write_%0d", c), 32'(obs_write[c]), 32'd1);
            check($sformatf("hold_data_%0d", c), obs_data[c], prev_data[c]);
        end
        if (obs_write[c] && !wait_r[c]) begin
            if (exp_q[c].size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL spurious_write_%0d observed 0x%08h expected no transfer", c, obs_data[c]);
            end else begin
                word = exp_q[c].pop_front();
                check($sformatf("writedata_%0d", c), obs_data[c], word);
            end
            got_q[c].push_back(obs_data[c]);
            n_done[c]++;
        end
        prev_write[c] = obs_write[c];
        prev_wait[c]  = wait_r[c];
        prev_data[c]  = obs_data[c];

        if (run && !m_prev_run[c]) begin
            m_seq[c]    = 0;
            m_ovf[c]    = 1'b0;
            m_drop[c]   = 0;
            m_half_v[c] = 1'b0;
            m_ramp[c]   = '0;
        end
        if (!run) m_half_v[c] = 1'b0;
        if (run && adc_v[c]) begin
            s = adc_d[c];
`ifdef ADC_FIFO_WRITER_TESTPATTERN_EN
            if (test_mode) s = m_ramp[c];
`endif
            m_ramp[c] = m_ramp[c] + 1'b1;
            if (!m_half_v[c]) begin
                m_half[c]   = s;
                m_half_v[c] = 1'b1;
            end else begin
                m_half_v[c] = 1'b0;
                word = (32'(m_seq[c]) << 28) | (32'(m_half[c]) << 14) | 32'(s);
                if (exp_q[c].size() < D) begin
                    exp_q[c].push_back(word);
                    m_seq[c] = (m_seq[c] + 1) % 16;
                end else begin
                    m_ovf[c] = 1'b1;
                    if (m_drop[c] != 255) m_drop[c]++;
                end
            end
        end
        m_prev_run[c] = run;
    endtask

    // Scoreboard / model process
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) model_step(c);
    end

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || obs_write[0] || obs_write[1])
               && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $error("FAIL drain_timeout observed %0d cycles expected idle", k);
        end
    endtask

    task automatic run_restart();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        for (int c = 0; c < 2; c++) begin
            adc_d[c] = '0; adc_v[c] = 1'b0; wait_r[c] = 1'b0;
            n_done[c] = 0; m_ready[c] = 1'b0; prev_write[c] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("reset_write", 32'(obs_write[c]), 32'd0);
            check("reset_writedata", obs_data[c], 32'd0);
            check("reset_ovf", 32'(obs_ovf[c]), 32'd0);
            check("reset_drop_cnt", 32'(obs_drop[c]), 32'd0);
        end

        // Basic packing and capture latency on channel 0
        run = 1'b1;
        tick();
        adc_d[0] = 12'h123; adc_v[0] = 1'b1;
        tick();
        adc_d[0] = 12'h456;
        tick();
        adc_v[0] = 1'b0;
        check("latency_n_plus_1_write", 32'(obs_write[0]), 32'd0);
        tick();
        check("latency_n_plus_2_write", 32'(obs_write[0]), 32'd1);
        check("latency_n_plus_2_data", obs_data[0], 32'h0048C456);
        adc_d[0] = 12'hABC; adc_v[0] = 1'b1;
        tick();
        adc_d[0] = 12'hDEF;
        tick();
        adc_v[0] = 1'b0;
        wait_idle(100);
        check("basic_count", 32'(got_q[0].size()), 32'd2);
        check("basic_word0", got_q[0][0], 32'h0048C456);
        check("basic_word1", got_q[0][1], 32'h12AF0DEF);

        // Stall: five cycles of waitrequest during one write
        got_q[0].delete();
        wait_r[0] = 1'b1;
        adc_d[0] = 12'h111; adc_v[0] = 1'b1;
        tick();
        adc_d[0] = 12'h222;
        tick();
        adc_v[0] = 1'b0;
        tick();
        base = n_done[0];
        for (int i = 0; i < 5; i++) begin
            check("stall_write", 32'(obs_write[0]), 32'd1);
            check("stall_data", obs_data[0], 32'h20444222);
            tick();
        end
        wait_r[0] = 1'b0;
        tick();
        tick();
        check("stall_transfers", 32'(n_done[0] - base), 32'd1);
        check("stall_write_released", 32'(obs_write[0]), 32'd0);

        // Overflow on channel 1 with the slave stalled throughout
        got_q[1].delete();
        wait_r[1] = 1'b1;
        adc_v[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            adc_d[1] = W'($urandom);
            tick();
        end
        adc_v[1] = 1'b0;
        tick();
        check("ovf_flag", 32'(obs_ovf[1]), 32'd1);
        check("ovf_drop_cnt", 32'(obs_drop[1]), 32'd12);
        wait_r[1] = 1'b0;
        wait_idle(100);
        check("ovf_drained", 32'(got_q[1].size()), 32'd8);
        for (int i = 0; i < 8; i++) check("ovf_seq", 32'(got_q[1][i][31:28]), 32'(i));

        // Run abort: a lone half is discarded and the restart clears status
        got_q[1].delete();
        adc_d[1] = 12'h0AA; adc_v[1] = 1'b1;
        tick();
        adc_v[1] = 1'b0;
        run_restart();
        check("abort_ovf_cleared", 32'(obs_ovf[1]), 32'd0);
        check("abort_drop_cleared", 32'(obs_drop[1]), 32'd0);
        adc_d[1] = 12'h0BB; adc_v[1] = 1'b1;
        tick();
        adc_d[1] = 12'h0CC;
        tick();
        adc_v[1] = 1'b0;
        wait_idle(100);
        check("abort_count", 32'(got_q[1].size()), 32'd1);
        check("abort_word", got_q[1][0], 32'h002EC0CC);

        // Independence and sequence wrap: 17 pairs on both channels
        run_restart();
        got_q[0].delete();
        got_q[1].delete();
        adc_v[0] = 1'b1;
        adc_v[1] = 1'b1;
        for (int i = 0; i < 34; i++) begin
            adc_d[0] = W'($urandom);
            adc_d[1] = W'($urandom);
            wait_r[0] = i[0];
            tick();
        end
        adc_v[0] = 1'b0;
        adc_v[1] = 1'b0;
        wait_r[0] = 1'b0;
        wait_idle(200);
        for (int c = 0; c < 2; c++) begin
            check("wrap_count", 32'(got_q[c].size()), 32'd17);
            for (int i = 0; i < 17; i++) check("wrap_seq", 32'(got_q[c][i][31:28]), 32'(i % 16));
        end

        // Randomized traffic with run drops, test_mode, stalls and a mid-stream reset
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 2; c++) begin
                adc_v[c]  = 1'($urandom_range(0, 1));
                adc_d[c]  = W'($urandom);
                wait_r[c] = ($urandom_range(0, 3) == 0);
            end
            run       = ($urandom_range(0, 31) != 0);
            test_mode = 1'($urandom_range(0, 1));
            rst       = (i == 300);
            tick();
            if (i == 300) begin
                check("midreset_write_0", 32'(obs_write[0]), 32'd0);
                check("midreset_write_1", 32'(obs_write[1]), 32'd0);
            end
        end
        rst = 1'b0;
        run = 1'b1;
        test_mode = 1'b0;
        for (int c = 0; c < 2; c++) begin
            adc_v[c] = 1'b0;
            wait_r[c] = 1'b0;
        end
        wait_idle(200);

`ifdef ADC_FIFO_WRITER_TESTPATTERN_EN
        // Test pattern: ramp pairs replace the ADC data
        run_restart();
        test_mode = 1'b1;
        got_q[0].delete();
        for (int i = 0; i < 6; i++) begin
            adc_d[0] = W'($urandom);
            adc_v[0] = 1'b1;
            tick();
            adc_v[0] = 1'b0;
            tick();
        end
        wait_idle(100);
        test_mode = 1'b0;
        check("tp_count", 32'(got_q[0].size()), 32'd3);
        check("tp_word0", got_q[0][0], 32'h00000001);
        check("tp_word1", got_q[0][1], 32'h10008003);
        check("tp_word2", got_q[0][2], 32'h20010005);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_fifo_writer.md
# adc_fifo_writer

Writer-side front end for the two-channel readout FIFOs. Captures samples from two ADC channels, packs consecutive sample pairs into 32-bit words with a rolling sequence tag, and buffers them per channel. It then drives the `fifo_0_in` and `fifo_1_in` Avalon-MM write slave ports of the readout system, honouring `waitrequest`. Capture is gated by `run`, which is sourced from the system PIO export.

## Interface

Parameters:
- `ADC_WIDTH`, default 12: sample width, legal range 8..14.
- `DEPTH`, default 8: per-channel word buffer depth, power of 2, minimum 2.

Ports:
- `clk_clk` input 1: single clock; all logic on its rising edge.
- `reset_reset` input 1: synchronous, active-high reset.
- `run` input 1: capture enable.
- `test_mode` input 1: selects the internal ramp source; only used when the test-pattern macro is defined.
- `adc0_data` input ADC_WIDTH: channel 0 sample.
- `adc0_valid` input 1: channel 0 sample strobe.
- `adc1_data` input ADC_WIDTH: channel 1 sample.
- `adc1_valid` input 1: channel 1 sample strobe.
- `fifo_0_in_writedata` output 32: channel 0 write data.
- `fifo_0_in_write` output 1: channel 0 write request.
- `fifo_0_in_waitrequest` input 1: channel 0 stall.
- `fifo_1_in_writedata` output 32: channel 1 write data.
- `fifo_1_in_write` output 1: channel 1 write request.
- `fifo_1_in_waitrequest` input 1: channel 1 stall.
- `ovf_0`, `ovf_1` output 1: sticky per-channel overflow flags.
- `drop_cnt_0`, `drop_cnt_1` output 8: per-channel dropped-word counters, saturating.

## Operation

The two channels are identical and fully independent. Per channel:

- **Capture.** A sample is accepted when `valid & run`.
- **Pairing.** The pairer has two states, EVEN and ODD.
  - EVEN + accept: store the sample as the first half; go to ODD.
  - ODD + accept: form the word; go to EVEN.
- **Word format:**
  - `[31:28]`: seq, 4 bits.
  - `[27:14]`: first sample, zero-extended to 14 bits.
  - `[13:0]`: second sample, zero-extended to 14 bits.
- **Sequence tag.** seq starts at 0. It increments only when a word is accepted into the buffer, and wraps 15→0.
- **Run deassert.** When `run` deasserts while the pairer is in ODD, the stored half is discarded and the pairer returns to EVEN. Words already buffered continue to drain.
- **Run rising edge.** Clears `ovf`, `drop_cnt` and seq. The pairer is forced to EVEN.
- **Buffer.** Circular FIFO of DEPTH words.
  - Push: a formed word.
  - Pop: the write master completes a transfer.
- **Full buffer.**
  - Full with no pop in the same cycle: the formed word is dropped, `ovf` is set, `drop_cnt` increments (saturating at 255), and seq does not advance.
  - Full with a pop in the same cycle: the push is accepted and nothing is dropped.
- **Write master.** Two states, IDLE and WRITE.
  - IDLE, buffer non-empty: load the head word into `writedata`, assert `write`, go to WRITE.
  - WRITE, `waitrequest` high: hold `write` and `writedata` stable.
  - WRITE, `waitrequest` low: the transfer completes and the head is popped. If further words are buffered, load the next head and remain in WRITE (back-to-back). Otherwise deassert `write` and go to IDLE.
- **Empty buffer.** `write` is never asserted while the buffer is empty.

## Timing

- **Reset values.** All outputs are 0: `write`, `writedata`, `ovf`, `drop_cnt`. Internally, seq is 0, the pairer is EVEN, and the buffer is empty.
- **Reset mid-transfer.** Reset takes effect in the cycle it is sampled; an in-flight write is abandoned.
- **Capture latency.** Second sample accepted in cycle N → word in the buffer at N+1 → `write` asserted at N+2, with the buffer previously empty and the master IDLE.
- **Throughput.** With `waitrequest` low, one word per cycle sustained per channel. With one sample per cycle input, the channel needs at most 0.5 word per cycle.
- **Stall.** `waitrequest` is sampled on the same edge as `write`. No combinational path from `waitrequest` to `write` or `writedata`.
- **Run timing.** `run` is sampled each cycle. A `valid` coincident with the `run` rising edge is accepted, after the clear.
- **Run falling mid-write.** A transfer in progress when `run` falls completes normally.

## Configuration

Macro: `ADC_FIFO_WRITER_TESTPATTERN_EN`.

- **Defined.** When `test_mode` = 1, each channel replaces its ADC data with an internal ADC_WIDTH-bit ramp.
  - The ramp starts at 0 on reset or on the `run` rising edge.
  - It increments on each accepted sample and wraps.
  - The `valid` strobes still gate capture.
- **Undefined.** `test_mode` is ignored, the ramp logic is absent, and ADC data is always used.

## Test plan

All scenarios use ADC_WIDTH=12 and DEPTH=8.

- **Basic packing.**
  - Stimulus: `run`=1; ch0 samples 0x123, 0x456, 0xABC, 0xDEF; `waitrequest`=0.
  - Required: two writes, 0x0048C456 then 0x12AF0DEF.
  - Required: the first write is asserted 2 cycles after 0x456 is accepted.
- **Stall.**
  - Stimulus: hold `fifo_0_in_waitrequest`=1 for 5 cycles during a write.
  - Required: `write` and `writedata` are stable for all 5 cycles, and exactly one transfer completes.
- **Overflow.**
  - Stimulus: `waitrequest`=1 permanently; 20 sample pairs on ch1.
  - Required: 8 words buffered, `ovf_1`=1, `drop_cnt_1`=12.
  - Required: after `waitrequest` is released, the written seq values are 0..7 in order.
- **Run abort.**
  - Stimulus: one sample accepted, then `run` drops and rises again.
  - Required: no word is formed and the next word carries seq 0.
  - Required: `ovf` and `drop_cnt` are cleared on the rising edge.
- **Independence and wrap.**
  - Stimulus: 17 pairs on each channel simultaneously; ch0 `waitrequest` toggling, ch1 `waitrequest`=0.
  - Required: both channels emit 17 words with seq 0..15 then 0, with no cross-channel interaction.
- **Test pattern** (macro defined).
  - Stimulus: `test_mode`=1 and `valid` pulses.
  - Required: words are 0x00000001, 0x10008003, 0x20010005, i.e. ramp pairs (0,1), (2,3), (4,5).
